// File: rtl/lowx_mem_arbiter.sv
// lowx_mem_arbiter: shares one memory port between icache refills and dcache refills/writebacks,
// one transaction in flight. Define LOWX_ARB_PERF_EN to add grant/drop performance counters.
module lowx_mem_arbiter #(
   parameter int XLEN         = 32,
   parameter int BLK_SIZE     = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                ic_req_valid_i,
   output logic                ic_req_ready_o,
   input  logic [XLEN-1:0]     ic_req_addr_i,
   input  logic                ic_req_uncached_i,
   input  logic                ic_flush_i,
   output logic                ic_res_valid_o,
   output logic [BLK_SIZE-1:0] ic_res_blk_o,
   input  logic                dc_req_valid_i,
   output logic                dc_req_ready_o,
   input  logic [XLEN-1:0]     dc_req_addr_i,
   input  logic                dc_req_rw_i,
   input  logic [BLK_SIZE-1:0] dc_req_wdata_i,
   input  logic                dc_req_uncached_i,
   output logic                dc_res_valid_o,
   output logic [BLK_SIZE-1:0] dc_res_blk_o,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic [XLEN-1:0]     mem_req_addr_o,
   output logic                mem_req_rw_o,
   output logic [BLK_SIZE-1:0] mem_req_wdata_o,
   output logic                mem_req_uncached_o,
   input  logic                mem_res_valid_i,
   input  logic [BLK_SIZE-1:0] mem_res_blk_i,
   output logic                busy_o
`ifdef LOWX_ARB_PERF_EN
   ,
   output logic [31:0]         perf_ic_grants_o,
   output logic [31:0]         perf_dc_grants_o,
   output logic [31:0]         perf_ic_dropped_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

   state_t                r_state;
   state_t                w_next_state;
   logic [3:0]            r_starve_cnt;
   logic                  r_owner_ic;
   logic                  r_drop;
   logic [XLEN-1:0]       r_addr;
   logic                  r_rw;
   logic [BLK_SIZE-1:0]   r_wdata;
   logic                  r_uncached;
   logic                  w_grant_dc;
   logic                  w_grant_ic;
   logic                  w_res_fire;
   logic                  w_drop_eff;
   logic                  w_ic_res_vld;
   logic                  w_dc_res_vld;

   // DC wins ties until the icache has lost STARVE_LIMIT times in a row.
   assign w_grant_dc   = (r_state == S_IDLE) && dc_req_valid_i &&
                         (!ic_req_valid_i || (r_starve_cnt < LP_STARVE));
   assign w_grant_ic   = (r_state == S_IDLE) && !w_grant_dc && ic_req_valid_i && !ic_flush_i;
   assign w_res_fire   = (r_state == S_WAIT) && mem_res_valid_i;
   // A flush coinciding with the response cycle also kills that response.
   assign w_drop_eff   = r_drop || (ic_flush_i && r_owner_ic);
   assign w_ic_res_vld = w_res_fire && r_owner_ic && !w_drop_eff;
   assign w_dc_res_vld = w_res_fire && !r_owner_ic;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_grant_dc || w_grant_ic) w_next_state = S_REQ;
         S_REQ:   if (mem_req_ready_i) w_next_state = S_WAIT;
         S_WAIT:  if (mem_res_valid_i) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      ic_req_ready_o     = w_grant_ic;
      dc_req_ready_o     = w_grant_dc;
      busy_o             = (r_state != S_IDLE);
      mem_req_valid_o    = (r_state == S_REQ);
      mem_req_addr_o     = '0;
      mem_req_rw_o       = 1'b0;
      mem_req_wdata_o    = '0;
      mem_req_uncached_o = 1'b0;
      if (r_state == S_REQ) begin
         mem_req_addr_o     = r_addr;
         mem_req_rw_o       = r_rw;
         mem_req_wdata_o    = r_wdata;
         mem_req_uncached_o = r_uncached;
      end
      ic_res_valid_o = w_ic_res_vld;
      ic_res_blk_o   = w_ic_res_vld ? mem_res_blk_i : '0;
      dc_res_valid_o = w_dc_res_vld;
      dc_res_blk_o   = w_dc_res_vld ? mem_res_blk_i : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_starve_cnt <= '0;
         r_owner_ic   <= 1'b0;
         r_drop       <= 1'b0;
      end else begin
         if (w_grant_dc) begin
            r_owner_ic <= 1'b0;
            if (ic_req_valid_i && (r_starve_cnt != 4'hF)) r_starve_cnt <= r_starve_cnt + 4'd1;
         end else if (w_grant_ic) begin
            r_owner_ic   <= 1'b1;
            r_starve_cnt <= '0;
         end
         if (w_next_state == S_IDLE)                              r_drop <= 1'b0;
         else if ((r_state != S_IDLE) && ic_flush_i && r_owner_ic) r_drop <= 1'b1;
      end
   end

   // Payload is only visible while in REQ, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (w_grant_dc) begin
         r_addr     <= dc_req_addr_i;
         r_rw       <= dc_req_rw_i;
         r_wdata    <= dc_req_wdata_i;
         r_uncached <= dc_req_uncached_i;
      end else if (w_grant_ic) begin
         r_addr     <= ic_req_addr_i;
         r_rw       <= 1'b0;
         r_wdata    <= '0;
         r_uncached <= ic_req_uncached_i;
      end
   end

`ifdef LOWX_ARB_PERF_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_ic_grants_o  <= '0;
         perf_dc_grants_o  <= '0;
         perf_ic_dropped_o <= '0;
      end else begin
         if (w_grant_ic) perf_ic_grants_o <= perf_ic_grants_o + 32'd1;
         if (w_grant_dc) perf_dc_grants_o <= perf_dc_grants_o + 32'd1;
         if (w_res_fire && r_owner_ic && w_drop_eff) perf_ic_dropped_o <= perf_ic_dropped_o + 32'd1;
      end
   end
`endif

endmodule

// File: doc/lowx_mem_arbiter.md
Name: lowx_mem_arbiter

Overview:
Shares the single lower-level memory port between instruction-cache refills and data-cache refills/writebacks. Sits between the two caches and the memory interconnect. Serialises exactly one outstanding transaction at a time and routes each response back to the requester that issued it. Includes a starvation guard and drops icache responses orphaned by a pipeline flush.

Parameters:
XLEN, 32, address width in bits
BLK_SIZE, 128, cache block width in bits (response and write-data width)
STARVE_LIMIT, 4, consecutive icache losses before the icache is forced to win (range 1..15)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
ic_req_valid_i  input  1  icache miss request
ic_req_ready_o  output  1  icache request accepted this cycle
ic_req_addr_i  input  XLEN  icache block address
ic_req_uncached_i  input  1  icache uncached attribute
ic_flush_i  input  1  pipeline flush; invalidates the pending icache transaction
ic_res_valid_o  output  1  icache response pulse
ic_res_blk_o  output  BLK_SIZE  icache response block
dc_req_valid_i  input  1  dcache request
dc_req_ready_o  output  1  dcache request accepted this cycle
dc_req_addr_i  input  XLEN  dcache address
dc_req_rw_i  input  1  1 = write, 0 = read
dc_req_wdata_i  input  BLK_SIZE  dcache write block
dc_req_uncached_i  input  1  dcache uncached attribute
dc_res_valid_o  output  1  dcache response pulse
dc_res_blk_o  output  BLK_SIZE  dcache response block
mem_req_valid_o  output  1  memory request valid
mem_req_ready_i  input  1  memory accepts request
mem_req_addr_o  output  XLEN  latched address
mem_req_rw_o  output  1  latched rw (always 0 for icache)
mem_req_wdata_o  output  BLK_SIZE  latched write data
mem_req_uncached_o  output  1  latched uncached attribute
mem_res_valid_i  input  1  memory response valid
mem_res_blk_i  input  BLK_SIZE  memory response block
busy_o  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset: IDLE; all outputs 0; starve_cnt = 0; drop = 0; owner = DC.
- IDLE, grant selection:
  - If dc valid and (ic not valid or starve_cnt < STARVE_LIMIT): grant DC.
  - Else if ic valid and !ic_flush_i: grant IC.
  - With an ic request present, ic_flush_i suppresses the IC grant (DC may still win).
- IDLE, on grant:
  - Pulse the winner's *_req_ready_o combinationally in the same cycle.
  - Latch addr/rw/wdata/uncached and owner; go to REQ.
  - Latency: acceptance cycle N → mem_req_valid_o high in cycle N+1.
- starve_cnt:
  - Increments (saturating at 15) when DC is granted while ic_req_valid_i is high.
  - Clears when IC is granted.
- REQ:
  - mem_req_valid_o = 1 with payload held stable until mem_req_ready_i; then WAIT.
  - Valid is never retracted, including on flush.
- WAIT: on mem_res_valid_i, forward to the owner in the same cycle and go to IDLE.
  - If owner = IC, ic_res_valid_o = !drop and ic_res_blk_o = mem_res_blk_i.
  - If owner = DC, dc_res_valid_o = 1 and dc_res_blk_o = mem_res_blk_i. A write also receives a response (ack); its blk content is don't-care.
  - The new grant is evaluated in the following IDLE cycle, so back-to-back spacing is at least 1 idle cycle.
- drop flag:
  - Set by ic_flush_i in REQ or WAIT when owner = IC.
  - Cleared on return to IDLE.
  - ic_flush_i has no effect on a DC-owned transaction.
- Non-forwarded response outputs are 0 (blk outputs are 0 when their valid is 0).
- mem_res_valid_i in IDLE or REQ is spurious and ignored.
- Asynchronous reset mid-transaction: immediate return to IDLE. Any later memory response for that transaction is ignored.

Optional Feature:
- Macro LOWX_ARB_PERF_EN.
- When defined, adds three 32-bit outputs, reset 0 and wrapping on overflow:
  - perf_ic_grants_o: increments on each IC grant.
  - perf_dc_grants_o: increments on each DC grant.
  - perf_ic_dropped_o: increments when a response is discarded because drop = 1.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Lone ic request, addr 0x8000_0040:
  - ic_req_ready_o pulses in cycle 0; mem_req_valid_o is high in cycle 1 with addr 0x8000_0040, rw 0.
  - mem_res_valid_i with blk 0xDEAD…BEEF → ic_res_valid_o for exactly 1 cycle with that blk; dc_res_valid_o stays 0.
- ic and dc valid in the same IDLE cycle, STARVE_LIMIT = 4:
  - DC wins rounds 1–4.
  - Round 5 grants IC even though dc is still valid; starve_cnt then reads 0.
- dc write, addr 0x8000_1000, wdata 0x1234…:
  - Hold mem_req_ready_i low for 3 cycles → mem_req_* stays stable and valid.
  - On ready, the response pulses dc_res_valid_o once.
- IC transaction in WAIT; assert ic_flush_i for 1 cycle, then deliver the response:
  - ic_res_valid_o stays 0; busy_o drops next cycle.
  - With LOWX_ARB_PERF_EN, perf_ic_dropped_o = 1.
- rst_ni low for 1 cycle while in REQ:
  - All outputs are 0 immediately; a mem_res_valid_i 2 cycles later produces no response pulse.
- ic_req_valid_i and ic_flush_i high together in IDLE, dc idle → no grant, ic_req_ready_o = 0, mem_req_valid_o stays 0.
